// File: rtl/id_mod.sv
// Instruction-decode stage: register file with WB bypass, control/immediate decode,
// load-use hazard detection and the ID/EX pipeline register.
module id_mod (
  input  logic        clk_cpu,
  input  logic        rst,
  input  logic [31:0] ir_d,
  input  logic [31:0] pc_d,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] imm,
  output logic [31:0] ire,
  output logic [31:0] ctr,
  output logic [31:0] pce,
  output logic        stall,
  input  logic [4:0]  dbg_ra,
  output logic [31:0] dbg_rd
);

  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;

  logic [31:0] regs_q [32];
  logic [31:0] a_q, b_q, imm_q, ire_q, pce_q;
  logic [7:0]  ctr_q;
  logic [31:0] a_d, b_d, imm_d;
  logic [7:0]  ctr_d;
  logic        uses_rs2;
  logic        stall_raw;
  logic [31:0] rs1_val, rs2_val;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2;

  assign opcode = ir_d[6:0];
  assign funct3 = ir_d[14:12];
  assign funct7 = ir_d[31:25];
  assign rs1    = ir_d[19:15];
  assign rs2    = ir_d[24:20];

  // Same-cycle WB write is forwarded so ID never reads a stale value.
  function automatic logic [31:0] rf_read(input logic [4:0] ra, input logic [31:0] stored,
                                          input logic we, input logic [4:0] wa,
                                          input logic [31:0] wd);
    if (ra == 5'd0)
      return 32'd0;
    else if (we && (wa == ra))
      return wd;
    else
      return stored;
  endfunction

  assign rs1_val = rf_read(rs1, regs_q[rs1], wb_we, wb_rd, wb_data);
  assign rs2_val = rf_read(rs2, regs_q[rs2], wb_we, wb_rd, wb_data);
  assign dbg_rd  = rf_read(dbg_ra, regs_q[dbg_ra], wb_we, wb_rd, wb_data);

  always_comb begin
    ctr_d    = 8'h00;
    imm_d    = 32'd0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        uses_rs2 = 1'b1;
        if (funct3 == 3'b000 && funct7 == 7'h00) ctr_d = 8'h80;
        else if (funct3 == 3'b000 && funct7 == 7'h20) ctr_d = 8'h88;
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          ctr_d = 8'hC0;
          imm_d = {{20{ir_d[31]}}, ir_d[31:20]};
        end else if (funct3 == 3'b001 && funct7 == 7'h00) begin
          ctr_d = 8'hD0;
          imm_d = {{20{ir_d[31]}}, ir_d[31:20]};
        end
      end
      OP_AUIPC: begin
        ctr_d = 8'h98;
        imm_d = {ir_d[31:12], 12'd0};
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          ctr_d = 8'hC6;
          imm_d = {{20{ir_d[31]}}, ir_d[31:20]};
        end
      end
      OP_STORE: begin
        uses_rs2 = 1'b1;
        if (funct3 == 3'b010) begin
          ctr_d = 8'h60;
          imm_d = {{20{ir_d[31]}}, ir_d[31:25], ir_d[11:7]};
        end
      end
      OP_BR: begin
        uses_rs2 = 1'b1;
        if (funct3 == 3'b000 || funct3 == 3'b110) begin
          ctr_d = 8'h09;
          imm_d = {{19{ir_d[31]}}, ir_d[31], ir_d[7], ir_d[30:25], ir_d[11:8], 1'b0};
        end
      end
      OP_JAL: begin
        ctr_d = 8'h81;
        imm_d = {{11{ir_d[31]}}, ir_d[31], ir_d[19:12], ir_d[20], ir_d[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // jal carries its link address through the A operand.
  assign a_d = (opcode == OP_JAL) ? (pc_d + 32'd4) : rs1_val;
  assign b_d = (opcode == OP_JAL) ? 32'd0 : rs2_val;

  assign stall_raw = ctr_q[1] && (ire_q[11:7] != 5'd0) &&
                     ((ire_q[11:7] == rs1) || (uses_rs2 && (ire_q[11:7] == rs2)));
  assign stall = stall_raw && !flush;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (wb_we && (wb_rd != 5'd0)) begin
      regs_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk_cpu) begin
    if (rst || flush || stall_raw) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      imm_q <= 32'd0;
      ire_q <= 32'd0;
      ctr_q <= 8'h00;
      pce_q <= 32'd0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      imm_q <= imm_d;
      ire_q <= ir_d;
      ctr_q <= ctr_d;
      pce_q <= pc_d;
    end
  end

  assign a   = a_q;
  assign b   = b_q;
  assign imm = imm_q;
  assign ire = ire_q;
  assign ctr = {24'd0, ctr_q};
  assign pce = pce_q;

endmodule

// File: tb/tb_id_mod.sv
// Scoreboard bench for id_mod: instructions are built from chosen fields and the
// expected ID/EX contents come from those fields, not from decoding bits.
module tb_id_mod;
  logic        clk_cpu = 1'b0;
  logic        rst;
  logic [31:0] ir_d, pc_d, wb_data;
  logic        wb_we, flush;
  logic [4:0]  wb_rd, dbg_ra;
  logic [31:0] a, b, imm, ire, ctr, pce, dbg_rd;
  logic        stall;

  always #5 clk_cpu = ~clk_cpu;

  id_mod dut (
    .clk_cpu(clk_cpu), .rst(rst), .ir_d(ir_d), .pc_d(pc_d),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
    .a(a), .b(b), .imm(imm), .ire(ire), .ctr(ctr), .pce(pce),
    .stall(stall), .dbg_ra(dbg_ra), .dbg_rd(dbg_rd)
  );

  typedef enum int {K_ADD, K_SUB, K_ADDI, K_SLLI, K_AUIPC, K_LW, K_SW,
                    K_BEQ, K_BLTU, K_JAL, K_NOP0, K_BAD} kind_e;
  typedef struct { logic [31:0] a, b, imm, ire, ctr, pce; } idex_t;
  typedef struct { logic chk_stall; logic stall; logic [31:0] dbg; } comb_t;

  idex_t       seq_q[$];
  comb_t       comb_q[$];
  logic [31:0] mregs [32];
  logic        m_ld_pending;
  logic [4:0]  m_ld_rd;
  logic        last_stall;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic logic [31:0] ctr_of(input kind_e k);
    case (k)
      K_ADD:   return 32'h80;
      K_SUB:   return 32'h88;
      K_ADDI:  return 32'hC0;
      K_SLLI:  return 32'hD0;
      K_AUIPC: return 32'h98;
      K_LW:    return 32'hC6;
      K_SW:    return 32'h60;
      K_BEQ, K_BLTU: return 32'h09;
      K_JAL:   return 32'h81;
      default: return 32'h00;
    endcase
  endfunction

  function automatic logic [31:0] enc(input kind_e k, input logic [4:0] rd, rs1, rs2,
                                      input logic [31:0] iv);
    case (k)
      K_ADD:   return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
      K_SUB:   return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
      K_ADDI:  return {iv[11:0], rs1, 3'b000, rd, 7'h13};
      K_SLLI:  return {7'h00, iv[4:0], rs1, 3'b001, rd, 7'h13};
      K_AUIPC: return {iv[31:12], rd, 7'h17};
      K_LW:    return {iv[11:0], rs1, 3'b010, rd, 7'h03};
      K_SW:    return {iv[11:5], rs2, rs1, 3'b010, iv[4:0], 7'h23};
      K_BEQ:   return {iv[12], iv[10:5], rs2, rs1, 3'b000, iv[4:1], iv[11], 7'h63};
      K_BLTU:  return {iv[12], iv[10:5], rs2, rs1, 3'b110, iv[4:1], iv[11], 7'h63};
      K_JAL:   return {iv[20], iv[10:1], iv[11], iv[19:12], rd, 7'h6F};
      K_BAD:   return {iv[11:0], rs1, 3'b000, rd, 7'h03};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] mread(input logic [4:0] ra, input logic [31:0] stored,
                                        input logic we, input logic [4:0] wa,
                                        input logic [31:0] wd);
    if (ra == 5'd0) return 32'd0;
    if (we && wa == ra) return wd;
    return stored;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs and push what the model expects to see.
  task automatic drive(input logic r, input kind_e k, input logic [31:0] ir, pc, iv,
                       input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbd,
                       input logic fl, input logic [4:0] dra);
    logic [4:0]  f1, f2;
    logic [31:0] v1, v2;
    logic        uses2, st;
    idex_t       e;
    comb_t       c;
    @(posedge clk_cpu);
    #2;
    rst = r; ir_d = ir; pc_d = pc; wb_we = wbwe; wb_rd = wbrd; wb_data = wbd;
    flush = fl; dbg_ra = dra;
    f1 = ir[19:15];
    f2 = ir[24:20];
    v1 = mread(f1, mregs[f1], wbwe, wbrd, wbd);
    v2 = mread(f2, mregs[f2], wbwe, wbrd, wbd);
    uses2 = (k == K_ADD || k == K_SUB || k == K_SW || k == K_BEQ || k == K_BLTU);
    st = !fl && m_ld_pending && m_ld_rd != 5'd0 &&
         (m_ld_rd == f1 || (uses2 && m_ld_rd == f2));
    c.chk_stall = !r;
    c.stall = st;
    c.dbg = mread(dra, mregs[dra], wbwe, wbrd, wbd);
    comb_q.push_back(c);
    e = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    if (r) begin
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      m_ld_pending = 1'b0;
      last_stall = 1'b0;
    end else begin
      if (!(fl || st)) begin
        e.a   = (k == K_JAL) ? pc + 32'd4 : v1;
        e.b   = (k == K_JAL) ? 32'd0 : v2;
        e.imm = (k == K_ADD || k == K_SUB || k == K_NOP0 || k == K_BAD) ? 32'd0 : iv;
        e.ire = ir;
        e.ctr = ctr_of(k);
        e.pce = pc;
      end
      m_ld_pending = !(fl || st) && (k == K_LW);
      m_ld_rd = ir[11:7];
      if (wbwe && wbrd != 5'd0) mregs[wbrd] = wbd;
      last_stall = st;
    end
    seq_q.push_back(e);
  endtask

  always @(posedge clk_cpu) begin
    idex_t e;
    #1;
    if (seq_q.size() > 0) begin
      e = seq_q.pop_front();
      check("a", a, e.a);
      check("b", b, e.b);
      check("imm", imm, e.imm);
      check("ire", ire, e.ire);
      check("ctr", ctr, e.ctr);
      check("pce", pce, e.pce);
    end
  end

  always @(negedge clk_cpu) begin
    comb_t c;
    if (comb_q.size() > 0) begin
      c = comb_q.pop_front();
      if (c.chk_stall) check("stall", {31'd0, stall}, {31'd0, c.stall});
      check("dbg_rd", dbg_rd, c.dbg);
    end
  end

  initial begin
    kind_e       k;
    logic [31:0] ir, pc, iv, rnd;
    logic        fl, r;
    rst = 1'b1; ir_d = '0; pc_d = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; dbg_ra = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    m_ld_pending = 1'b0; m_ld_rd = '0; last_stall = 1'b0;

    drive(1, K_NOP0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, K_NOP0, 0, 0, 0, 1, 5'd3, 32'h55, 0, 3);
    // bypass from WB straight into the add operands
    drive(0, K_ADD, enc(K_ADD, 1, 5, 0, 0), 32'h0, 0, 1, 5'd5, 32'h1234, 0, 5);
    drive(0, K_ADDI, 32'hFFF00113, 32'h40, 32'hFFFFFFFF, 0, 0, 0, 0, 5);
    // load-use: the add is held upstream while stall is high
    drive(0, K_LW, enc(K_LW, 3, 0, 0, 0), 32'h44, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++)
      drive(0, K_ADD, enc(K_ADD, 4, 3, 3, 0), 32'h48, 0, 0, 0, 0, 0, 4);
    drive(0, K_JAL, 32'h008000EF, 32'h100, 32'h8, 0, 0, 0, 0, 1);
    drive(0, K_JAL, 32'h008000EF, 32'h100, 32'h8, 0, 0, 0, 1, 1);
    drive(0, K_NOP0, 0, 32'h104, 0, 1, 5'd0, 32'hFFFF, 0, 0);
    drive(0, K_JAL, 32'h008000EF, 32'hFFFFFFFC, 32'h8, 0, 0, 0, 0, 0);

    k = K_NOP0; ir = 0; pc = 0; iv = 0;
    for (int n = 0; n < 800; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      fl = ($urandom_range(0, 9) == 0);
      if (!last_stall) begin
        k = kind_e'($urandom_range(0, 11));
        rnd = $urandom;
        case (k)
          K_ADDI, K_LW, K_SW, K_BAD: iv = {{20{rnd[11]}}, rnd[11:0]};
          K_SLLI:        iv = {27'd0, rnd[4:0]};
          K_AUIPC:       iv = {rnd[19:0], 12'd0};
          K_BEQ, K_BLTU: iv = {{19{rnd[12]}}, rnd[12:1], 1'b0};
          K_JAL:         iv = {{11{rnd[20]}}, rnd[20:1], 1'b0};
          default:       iv = 32'd0;
        endcase
        ir = enc(k, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), iv);
        rnd = $urandom;
        pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : {rnd[31:2], 2'b00};
      end
      drive(r, k, ir, pc, iv, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom, fl, 5'($urandom_range(0, 31)));
    end

    drive(0, K_NOP0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk_cpu);
    #3;
    n_checks++;
    if (seq_q.size() == 0 && comb_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending expected 0/0", seq_q.size(), comb_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
